// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: fetch PC, pipelined imem reads, instruction buffer, redirect/discard.
// Optional misaligned-target fault entry enabled by defining CPU_IFETCH_ALIGN_CHECK_EN.
module cpu_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p2_bubble,
  input  logic        p4_jump_taken,
  input  logic [31:0] p4_jump_addr,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid,
  output logic        p2_fetch_fault,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] buf_instr [FIFO_DEPTH];
  logic [DATA_W-1:0] buf_pc    [FIFO_DEPTH];

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, outstanding, discard;
  logic [DATA_W-1:0] fetch_pc, resp_pc;
  logic [DATA_W-1:0] last_instr, last_pc;

  logic [CW:0]       occupancy;
  logic [CW-1:0]     out_after_resp;
  logic [DATA_W-1:0] jump_tgt;
  logic              fetch_block;
  logic              issue, do_pop, resp_drop, resp_push, push;
  logic [DATA_W-1:0] push_instr, push_pc;

`ifdef CPU_IFETCH_ALIGN_CHECK_EN
  logic              buf_fault [FIFO_DEPTH];
  logic              fault_hold, fault_pending;
  logic [DATA_W-1:0] fault_pc;
  logic              fault_push;

  assign jump_tgt    = p4_jump_addr;
  assign fetch_block = fault_hold;
  assign fault_push  = fault_pending && (discard == '0) && !p4_jump_taken;
`else
  // Low address bits are dropped so every redirect lands on a word boundary.
  assign jump_tgt    = p4_jump_addr & ~32'h3;
  assign fetch_block = 1'b0;
`endif

  always_comb begin
    occupancy      = {1'b0, count} + {1'b0, outstanding};
    imem_req       = !reset && !p4_jump_taken && !fetch_block && (occupancy < DEPTH_V);
    imem_addr      = fetch_pc;
    issue          = imem_req && imem_gnt;
    p2_instr_valid = (count != '0);
    do_pop         = p2_instr_valid && !stall && !p2_bubble && !p4_jump_taken;
    out_after_resp = (imem_rvalid && outstanding != '0) ? outstanding - CW'(1) : outstanding;
    resp_drop      = imem_rvalid && (discard != '0);
    resp_push      = imem_rvalid && (discard == '0) && !p4_jump_taken;
    push           = resp_push;
    push_instr     = imem_rdata;
    push_pc        = resp_pc;
`ifdef CPU_IFETCH_ALIGN_CHECK_EN
    if (fault_push) begin
      push       = 1'b1;
      push_instr = '0;
      push_pc    = fault_pc;
    end
    p2_fetch_fault = p2_instr_valid && buf_fault[rd_ptr];
`else
    p2_fetch_fault = 1'b0;
`endif
    p2_instr = p2_instr_valid ? buf_instr[rd_ptr] : last_instr;
    p2_pc    = p2_instr_valid ? buf_pc[rd_ptr]    : last_pc;
  end

  // Control state: pointers, counters, fetch/response PCs
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
    end else if (p4_jump_taken) begin
      // Everything still in flight after this cycle's response is stale.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= out_after_resp;
      discard     <= out_after_resp;
      fetch_pc    <= jump_tgt;
      resp_pc     <= jump_tgt;
    end else begin
      if (issue)     fetch_pc <= fetch_pc + 32'd4;
      if (resp_push) resp_pc  <= resp_pc + 32'd4;
      if (resp_drop) discard  <= discard - CW'(1);
      if (push)      wr_ptr   <= wr_ptr + PW'(1);
      if (do_pop)    rd_ptr   <= rd_ptr + PW'(1);
      outstanding <= out_after_resp + CW'(issue);
      count       <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Last presented word, shown while the buffer is empty
  always_ff @(posedge clock) begin
    if (reset) begin
      last_instr <= '0;
      last_pc    <= '0;
    end else if (p2_instr_valid) begin
      last_instr <= buf_instr[rd_ptr];
      last_pc    <= buf_pc[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_instr[wr_ptr] <= push_instr;
      buf_pc[wr_ptr]    <= push_pc;
`ifdef CPU_IFETCH_ALIGN_CHECK_EN
      buf_fault[wr_ptr] <= fault_push;
`endif
    end
  end

`ifdef CPU_IFETCH_ALIGN_CHECK_EN
  // Misaligned redirect: stop fetching, queue one fault marker after stale data drains
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_hold    <= 1'b0;
      fault_pending <= 1'b0;
      fault_pc      <= '0;
    end else if (p4_jump_taken) begin
      fault_hold    <= (p4_jump_addr[1:0] != 2'b00);
      fault_pending <= (p4_jump_addr[1:0] != 2'b00);
      fault_pc      <= p4_jump_addr;
    end else if (fault_push) begin
      fault_pending <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
Instruction fetch stage (pipeline stage 1). It keeps the fetch PC, issues pipelined word reads to instruction memory, and buffers returned words in a small FIFO. It presents p2_instr/p2_pc/p2_instr_valid to the decode stage, re-presents the same word when decode raises p2_bubble, and redirects on p4_jump_taken. Words fetched before a redirect are discarded.

Parameters:
RESET_VECTOR, 32'hFFFF0000, first fetch address after reset.
FIFO_DEPTH, 4, instruction buffer entries; power of 2, >=2; also bounds (buffered + outstanding).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; decode does not consume this cycle
p2_bubble  input  1  decode hazard; head word must be re-presented next cycle
p4_jump_taken  input  1  redirect request from execute/complete
p4_jump_addr  input  32  redirect target
p2_instr  output  32  instruction word at FIFO head
p2_pc  output  32  address of p2_instr
p2_instr_valid  output  1  FIFO head valid
p2_fetch_fault  output  1  misaligned-target fault marker (see Optional Feature)
imem_req  output  1  read request
imem_addr  output  32  word address, [1:0]=00
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid; responses in request order, >=1 cycle after grant
imem_rdata  input  32  read data

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_VECTOR, resp_pc=RESET_VECTOR, FIFO empty, outstanding=0, discard=0. Outputs during and after reset: imem_req=0, p2_instr_valid=0, p2_instr=0, p2_pc=0, p2_fetch_fault=0.
- Instruction memory is reset together with this block; no responses arrive for pre-reset requests.
- Request rule: imem_req=1 iff !reset && !p4_jump_taken && !fault_hold && (fifo_count+outstanding < FIFO_DEPTH). imem_addr=fetch_pc.
  - On imem_req&&imem_gnt: fetch_pc+=4 (wraps mod 2^32) and outstanding++.
- Response rule: on imem_rvalid, outstanding-- in all cases.
  - If discard>0: discard-- and the data is dropped.
  - Otherwise push {imem_rdata, resp_pc} and resp_pc+=4.
- Outputs: p2_instr, p2_pc and p2_instr_valid come combinationally from the FIFO head; p2_instr_valid=(fifo_count!=0). When the FIFO is empty, p2_instr and p2_pc hold their last values.
- Pop: when p2_instr_valid && !stall && !p2_bubble && !p4_jump_taken.
  - stall or p2_bubble: head held unchanged. Fetching continues until the FIFO plus outstanding count is full.
- Simultaneous push and pop: both happen; count is unchanged. A push into a full FIFO cannot occur because the request rule prevents it.
- Redirect (p4_jump_taken=1): takes priority over push, pop and request.
  - FIFO cleared; fetch_pc and resp_pc set to p4_jump_addr.
  - discard = outstanding after this cycle's response (if any) has been accounted for. A response arriving in the same cycle is dropped.
  - The next cycle's imem_req addresses the target.
- Repeated redirect while discard>0: discard is recomputed from the current outstanding count; it never accumulates.
- Latency: with single-cycle memory (gnt in cycle N, rvalid in N+1), p2_instr_valid rises in cycle N+2. The redirect-to-valid minimum is 3 cycles.
- Counters: outstanding and discard are each clog2(FIFO_DEPTH)+1 bits wide and must never underflow.

Optional Feature:
Macro: CPU_IFETCH_ALIGN_CHECK_EN.
- Defined: a redirect with p4_jump_addr[1:0]!=0 does not fetch. fault_hold is set and a single FIFO entry is pushed once discard reaches 0. That entry presents p2_instr_valid=1, p2_fetch_fault=1, p2_instr=0, p2_pc=p4_jump_addr. No further requests are issued until the next redirect or reset. The entry is popped normally.
- Not defined: p4_jump_addr[1:0] is forced to 00, p2_fetch_fault is tied to 0, and fault_hold does not exist.

Test Plan:
- Reset release, 1-cycle memory returning addr as data: imem_addr=FFFF0000,…04,…08 on consecutive cycles; p2_instr_valid rises 2 cycles after first grant; p2_pc=FFFF0000 then FFFF0004; one instruction per cycle with no stall.
- stall held 6 cycles: at most FIFO_DEPTH=4 words buffered; imem_req drops once count+outstanding=4; p2_pc constant; after release, words FFFF0000..0C are consumed in order with no gaps or duplicates.
- p2_bubble for 1 cycle at p2_pc=FFFF0008: same p2_instr/p2_pc presented the next cycle, then FFFF000C.
- Memory with 3-cycle latency and 2 outstanding, p4_jump_taken with target 00001000: both stale responses are dropped; first valid p2_pc=00001000 and p2_instr equals the memory word at 00001000.
- Redirect to 00002000 in the same cycle as imem_rvalid, followed by a second redirect to 00003000 one cycle later: no word from 00002000 or from the old stream reaches decode; first valid p2_pc=00003000.
- (CPU_IFETCH_ALIGN_CHECK_EN) redirect to 00001002: no imem_req; one entry with p2_fetch_fault=1, p2_pc=00001002; a subsequent redirect to 00001004 resumes normal fetch with p2_fetch_fault=0.
